// File: rtl/mux_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_pipe_pkg
// Description : Shared constants for the N-to-1 pipelined channel multiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_pipe_pkg;

    // Selection policy encoding carried on the MODE input
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

endpackage : mux_pipe_pkg
`default_nettype wire

// File: rtl/mux_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : mux_rr_pick
// Description : Combinational rotating-priority picker. Returns the first
//               requesting index at or after the base pointer, wrapping
//               around, using a doubled request vector shifted by the base.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_rr_pick #(
    parameter int NIN  = 4,
    parameter int SELW = $clog2(NIN)
) (
    input  logic [NIN-1:0]  req,
    input  logic [SELW-1:0] base,
    output logic [SELW-1:0] grant,
    output logic            grant_valid
);

    // Number of codes representable on the base/grant width
    localparam int NSEL = 1 << SELW;

    // One bit per code: set where the code is a real channel index
    localparam logic [NSEL-1:0] IDX_OK = NSEL'({NIN{1'b1}});

    logic [SELW-1:0]  base_eff;
    logic [2*NIN-1:0] dbl;
    logic [NIN-1:0]   rot;
    int               pos;

    // Fold an unused base code to 0 so the search window never starts past the end
    always_comb begin
        base_eff = IDX_OK[base] ? base : '0;
    end

    // Rotate requests so the base channel sits at bit 0; lowest set bit wins
    always_comb begin
        dbl         = {req, req};
        rot         = NIN'(dbl >> base_eff);
        grant       = '0;
        grant_valid = 1'b0;
        pos         = 0;
        // Descending scan: the last hit written is the lowest rotated index
        for (int i = NIN - 1; i >= 0; i--) begin
            if (rot[i]) begin
                pos = int'(base_eff) + i;
                if (pos >= NIN) begin
                    pos = pos - NIN;
                end
                grant       = SELW'(pos);
                grant_valid = 1'b1;
            end
        end
    end

endmodule : mux_rr_pick
`default_nettype wire

// File: rtl/mux_nto1_pipe.sv
`default_nettype none
// ============================================================================
// Module      : mux_nto1_pipe
// Description : Parametrised N-to-1 channel multiplexer with a one-entry
//               registered output and valid/ready flow control. Supports a
//               fixed select or round-robin arbitration across valid
//               channels; each output word is tagged with its source channel.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_nto1_pipe
    import mux_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NIN   = 4,
    parameter int SELW  = $clog2(NIN)
) (
    input  logic                 CLK,
    input  logic                 RSTB,
    input  logic [NIN*WIDTH-1:0] IN,
    input  logic [NIN-1:0]       IN_VLD,
    output logic [NIN-1:0]       IN_RDY,
    input  logic [SELW-1:0]      S,
    input  logic                 MODE,
    output logic [WIDTH-1:0]     Q,
    output logic                 Q_VLD,
    input  logic                 Q_RDY,
    output logic [SELW-1:0]      Q_SEL,
    output logic                 SEL_ERR
);

    // Number of codes representable on the select width
    localparam int NSEL = 1 << SELW;

    // One bit per select code: set where the code names a real channel.
    // Indexing these vectors by S avoids reading past IN_VLD when NIN is
    // not a power of two.
    localparam logic [NSEL-1:0] SEL_OK = NSEL'({NIN{1'b1}});

    logic [NSEL-1:0]  vld_ext;
    logic             s_in_range;
    logic             s_vld;

    logic [SELW-1:0]  ptr;
    logic [SELW-1:0]  rr_grant;
    logic             rr_valid;

    logic [SELW-1:0]  grant;
    logic             grant_valid;
    logic             load;
    logic [WIDTH-1:0] in_word;

    assign vld_ext    = NSEL'(IN_VLD);
    assign s_in_range = SEL_OK[S];
    assign s_vld      = vld_ext[S];

    mux_rr_pick #(
        .NIN  (NIN),
        .SELW (SELW)
    ) u_rr_pick (
        .req         (IN_VLD),
        .base        (ptr),
        .grant       (rr_grant),
        .grant_valid (rr_valid)
    );

    // Choose the granted channel for this cycle from the active policy
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        if (MODE == MODE_RR) begin
            grant       = rr_grant;
            grant_valid = rr_valid;
        end else begin
            grant       = S;
            grant_valid = s_in_range && s_vld;
        end
    end

    // Accept a word whenever the output slot is empty or draining this cycle
    assign load = (!Q_VLD || Q_RDY) && grant_valid;

    // One-hot ready towards the granted producer; independent of channel data
    generate
        for (genvar gi = 0; gi < NIN; gi++) begin : g_rdy
            assign IN_RDY[gi] = load && (grant == SELW'(gi));
        end
    endgenerate

    // Select the granted channel's word; an explicit compare loop keeps
    // unused select codes from reading outside the IN bus
    always_comb begin
        in_word = '0;
        for (int i = 0; i < NIN; i++) begin
            if (grant == SELW'(i)) begin
                in_word = IN[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output register: load on grant, empty on drain, otherwise hold
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            Q     <= '0;
            Q_SEL <= '0;
            Q_VLD <= 1'b0;
        end else if (load) begin
            Q     <= in_word;
            Q_SEL <= grant;
            Q_VLD <= 1'b1;
        end else if (Q_RDY) begin
            Q_VLD <= 1'b0;
        end
    end

    // Round-robin pointer moves past the winner only when a word is taken
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            ptr <= '0;
        end else if (load && (MODE == MODE_RR)) begin
            if (grant == SELW'(NIN - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= grant + 1'b1;
            end
        end
    end

    // Sticky flag for a fixed select naming a nonexistent channel under demand
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            SEL_ERR <= 1'b0;
        end else if ((MODE == MODE_FIXED) && !s_in_range && (|IN_VLD)) begin
            SEL_ERR <= 1'b1;
        end
    end

endmodule : mux_nto1_pipe
`default_nettype wire
